wb_write_arbiter: RTL
=====================

# wb_write_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage and the long-latency result return (multi-cycle multiply/divide and similar units). Long-latency results are buffered in a small in-order queue. Queued results drain into the port whenever the pipeline is not writing. A younger pipeline write to the same destination cancels the stale queued result. The block sits between WB_stage, the long-latency units and the register bank, and also exports a pending-write mask to the hazard unit.

## Interface
Parameters:
- `DEPTH`, default 2: pending-queue entries, power of two, 2..8.
- `STARVE_LIMIT`, default 4: consecutive blocked cycles before a pipeline bubble is requested, 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `pipe_we` in 1: pipeline WB write enable.
- `pipe_dst` in 5: pipeline destination register.
- `pipe_data` in 32: pipeline write data.
- `lat_valid` in 1: long-latency result valid.
- `lat_dst` in 5: long-latency destination register.
- `lat_data` in 32: long-latency result data.
- `lat_ready` out 1: queue can accept; equals queue not full (combinational from state only).
- `rf_we` out 1: register-file write enable (registered).
- `rf_dst` out 5: register-file write address (registered).
- `rf_data` out 32: register-file write data (registered).
- `stall_req` out 1: request to insert one WB bubble (registered).
- `pending_mask` out 32: bit r set when a valid queued entry targets register r (registered state, decoded).

## Operation
- **Queue.** Circular buffer of `DEPTH` entries, each holding {valid, dst, data}, with head and tail pointers and an occupancy count from 0 to `DEPTH`.
- **Enqueue.** On `lat_valid && lat_ready`, write the entry at tail with valid=1. In the same cycle, if `pipe_we && pipe_dst == lat_dst`, still consume the slot but with valid=0; the older result is dead on arrival.
- **Kill.** In any cycle with `pipe_we`, clear valid on every queued entry whose dst equals `pipe_dst`. The entry keeps its slot.
- **Port selection, one per cycle, priority order:**
  1. If `pipe_we`: register {1, `pipe_dst`, `pipe_data`}.
  2. Else if the head is valid: register {1, head.dst, head.data} and pop the head.
  3. Else: `rf_we` = 0. `rf_dst`/`rf_data` hold their last values.
- **Dead-head pop.** If the head entry is invalid and the queue is non-empty, pop it in that cycle regardless of `pipe_we`, with no write. At most one pop per cycle.
- **Simultaneous enqueue and pop** in one cycle: occupancy is unchanged and both pointers advance, wrapping modulo `DEPTH`.
- **Starvation counter.**
  - Increments each cycle the head is valid and `pipe_we` blocks it.
  - Clears when the head drains, is killed, or the queue empties.
  - When the counter reaches `STARVE_LIMIT`, `stall_req` is set on the next edge.
  - `stall_req` holds until the cycle after the blocked entry leaves the head.
- **Pipeline contract:** once `stall_req` is high, the pipeline drives `pipe_we` = 0 for at least one cycle. The arbiter still gives the pipeline priority if the contract is violated.
- **No special case for register 0;** the register bank handles it.

## Timing
- **Reset values** (async assert, synchronous deassert handled upstream):
  - `rf_we`=0, `rf_dst`=0, `rf_data`=0, `stall_req`=0, `pending_mask`=0.
  - Queue empty, pointers 0, counter 0, all valid bits 0.
  - `lat_ready`=1.
- **Reset mid-operation:** queued results are discarded without write.
- **Pipeline path latency:** 1 cycle, from inputs at edge N to `rf_*` valid after edge N+1.
- **Long-latency path latency:** at least 2 cycles. Enqueue at edge N; earliest `rf_we` from the head is after edge N+2, provided `pipe_we`=0 in cycle N+1.
- **Full queue:** `lat_ready`=0. The unit must hold `lat_valid`/`lat_dst`/`lat_data` stable until accepted.
- **`pending_mask`:** updates on the same edge as enqueue, kill and pop.

## Test plan
1. **Basic pipeline and queue writes.**
   - Stimulus: reset, then `pipe_we`=1, dst=5, data=0x11111111 for one cycle.
   - Required: next cycle `rf_we`=1, dst=5, data=0x11111111.
   - Stimulus: `lat_valid` with dst=7, data=0xAAAA0000, `pipe_we`=0.
   - Required: `pending_mask`[7]=1 one cycle later, then `rf_we`, dst=7 the following cycle, with the mask bit cleared.
2. **Full queue and backpressure.**
   - Stimulus: `DEPTH`=2, `pipe_we` held 1, two lat results enqueued.
   - Required: `lat_ready`=0 and a third `lat_valid` is held off.
   - Stimulus: release `pipe_we`.
   - Required: the queue drains in order over 2 cycles and `lat_ready` returns to 1.
3. **WAW kill.**
   - Stimulus: queued dst=9 data=0x1, then a pipeline write dst=9 data=0x2.
   - Required: the register file sees only 0x2 for r9; the dead entry pops with no `rf_we`; `pending_mask`[9] clears on the pipeline-write edge.
   - Also: the same-cycle `lat_dst`=`pipe_dst` case is never written.
4. **Starvation.**
   - Stimulus: `STARVE_LIMIT`=4, a valid head, `pipe_we`=1 continuously.
   - Required: `stall_req` rises after 4 blocked cycles.
   - Stimulus: bench drops `pipe_we` for 1 cycle.
   - Required: the head writes and `stall_req` falls on the next edge.
5. **Wrap-around.**
   - Stimulus: 10 back-to-back lat results with `pipe_we`=0.
   - Required: in-order writes dst=0..9, pointers wrap, occupancy never exceeds 1 or 2.
6. **Reset mid-operation.**
   - Stimulus: assert `rst_n`=0 with 2 entries queued and `stall_req`=1.
   - Required: all outputs go to reset values immediately, asynchronously, and no queued write ever appears after release.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs queued
// long-latency results, with WAW kill and starvation bubble request.
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_dst,
  input  logic [31:0] pipe_data,
  input  logic        lat_valid,
  input  logic [4:0]  lat_dst,
  input  logic [31:0] lat_data,
  output logic        lat_ready,
  output logic        rf_we,
  output logic [4:0]  rf_dst,
  output logic [31:0] rf_data,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [3:0]    LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        v;
    logic [4:0]  dst;
    logic [31:0] data;
  } ent_t;

  ent_t          q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [3:0]    starve;

  ent_t hd;
  logic nonempty;
  logic head_live;
  logic head_dead;
  logic head_kill;
  logic pop;
  logic enq;
  logic doa;

  assign lat_ready = (count != FULL);

  always_comb begin
    hd        = q[head];
    nonempty  = (count != '0);
    head_live = nonempty && hd.v;
    head_dead = nonempty && !hd.v;
    head_kill = head_live && pipe_we
              && (pipe_dst == hd.dst);
    pop       = head_dead
              || (head_live && !pipe_we);
    enq       = lat_valid && lat_ready;
    doa       = pipe_we && (pipe_dst == lat_dst);
  end

  // Killed entries keep their slot and drain later as silent pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pipe_we) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q[i].dst == pipe_dst) begin
            q[i].v <= 1'b0;
          end
        end
      end
      if (pop) begin
        q[head].v <= 1'b0;
        head      <= head + P_ONE;
      end
      if (enq) begin
        q[tail] <= '{v:    !doa,
                     dst:  lat_dst,
                     data: lat_data};
        tail    <= tail + P_ONE;
      end
      case ({enq, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_dst    <= '0;
      rf_data   <= '0;
      stall_req <= 1'b0;
      starve    <= '0;
    end else begin
      // Lags the counter by one edge, so it drops one cycle late.
      stall_req <= (starve >= LIMIT);
      if (!head_live || head_kill || !pipe_we) begin
        starve <= '0;
      end else if (starve != LIMIT) begin
        starve <= starve + 4'd1;
      end
      if (pipe_we) begin
        rf_we   <= 1'b1;
        rf_dst  <= pipe_dst;
        rf_data <= pipe_data;
      end else if (head_live) begin
        rf_we   <= 1'b1;
        rf_dst  <= hd.dst;
        rf_data <= hd.data;
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].v) begin
        pending_mask[q[i].dst] = 1'b1;
      end
    end
  end

endmodule
